lzc_pipe: RTL and testbench
===========================

Name: lzc_pipe

Overview:
- Pipelined, streaming leading-zero counter for the I2C peripheral datapath.
- Built from the existing 2-bit `enc` pair encoders and `lzc` merge stages, with a register after every tree level.
- Valid/ready handshake on both sides; sustains one word per cycle.
- Downstream consumers (normalisation and register readback) take `out_count` directly.

Parameters:
- WIDTH, 32, input word width; power of two, minimum 4.
- TAG_W, 4, sideband tag width carried alongside each word; minimum 1.
- LEVELS, $clog2(WIDTH), derived (not overridable); number of tree levels, equal to the pipeline depth.
- CW, $clog2(WIDTH)+1, derived; count width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data/in_tag are valid this cycle.
- in_ready  out  1  block accepts the input word this cycle.
- in_data  in  WIDTH  word to count.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result this cycle.
- out_count  out  CW  number of leading zeros, 0..WIDTH.
- out_zero  out  1  in_data was all zeros; equals out_count[CW-1].
- out_tag  out  TAG_W  tag of the word this result belongs to.

Behaviour:
- One clock, synchronous active-high reset.
- On reset:
  - all stage valid bits cleared;
  - out_valid=0, out_count=0, out_zero=0, out_tag=0;
  - data/tag stage registers cleared.
- Tree structure:
  - level 0: WIDTH/2 `enc` instances, each producing a 2-bit field.
  - level k (1..LEVELS-1): `lzc` merges with N=k+1 combine adjacent fields pairwise.
  - Registers sit after every level.
  - The final level register drives out_count/out_zero.
- Count encoding:
  - out_count is plain binary.
  - An all-zero input yields out_count = WIDTH, with only the MSB set and out_zero=1.
- Advance rule: single global enable, `adv = ~out_valid | out_ready`.
  - in_ready = adv, combinational, with no dependence on in_valid.
  - When adv=1, every stage loads from its predecessor.
  - Stage-0 valid loads `in_valid`.
  - When adv=0, every stage holds, including data, tag and valid.
- Latency: exactly LEVELS cycles from an accepted input (in_valid & in_ready) to out_valid, counting advancing cycles only. With no stalls, WIDTH=32 gives 5.
- Throughput: 1 word/cycle while out_ready=1.
- Bubbles: bubbles (valid=0 slots) propagate in place. Stage payloads advance whether or not the stage is valid; only the valid bit qualifies them.
- Ordering: results leave in acceptance order; tags are never reordered or dropped.
- Output stability: while out_valid=1 and out_ready=0, out_count, out_zero and out_tag are held stable.
- Input stall: in_valid=1 with in_ready=0 → the word is not taken; the upstream holds it.
- Reset mid-operation: all in-flight words are discarded. The first cycle after reset deasserts has out_valid=0 and in_ready=1.
- out_ready=1 while out_valid=0 is legal and has no effect.

Optional Feature:
- Macro: LZC_PIPE_NORM_EN.
- Defined:
  - Adds port `out_norm` (out, WIDTH): in_data shifted left by its leading-zero count, with zero fill.
  - The unshifted word travels down the pipeline alongside the count.
  - The shift is computed in the final stage from the final count; latency is unchanged (LEVELS).
  - All-zero input gives out_norm=0.
  - out_norm resets to 0 and obeys the same hold rule as out_count.
- Not defined:
  - No out_norm port.
  - No data-carry registers; only the tree fields and tag are pipelined.

Test Plan:
- Single words, out_ready=1, WIDTH=32:
  - 0x80000000 → count 0, zero 0;
  - 0x00010000 → count 15;
  - 0x00000001 → count 31;
  - 0x00000000 → count 32, zero 1.
  - Each appears exactly 5 cycles after acceptance.
  - With LZC_PIPE_NORM_EN, 0x00010000 → out_norm 0x80000000.
- Back-to-back stream of 8 words with tags 0..7, out_ready=1 → 8 consecutive out_valid cycles starting at cycle 5; tags in order 0..7; counts match a reference model.
- Backpressure: fill the pipe, then hold out_ready=0 for 4 cycles →
  - in_ready=0 throughout;
  - outputs held bit-stable;
  - no loss or duplication after release.
- Bubbles: in_valid pattern 1,0,1,0,0,1 → out_valid reproduces the same pattern 5 cycles later; tags correct.
- Reset mid-flight: assert reset with 3 words in flight →
  - the next cycle has out_valid=0, out_count=0, in_ready=1;
  - none of the 3 words ever appears at the output.
- Exhaustive single-bit sweep: in_data = 1<<i for i=0..31, plus random words → out_count = 31-i; random words match the model.

Source files
------------

// File: rtl/lzc_pipe.sv
// lzc_pipe: streaming leading-zero counter built as a registered enc/lzc merge tree, tag sideband carried alongside.
// Latency: LEVELS = $clog2(WIDTH) advancing cycles from accept (in_valid & in_ready) to out_valid; 1 word/cycle.
// Backpressure: one global enable adv = ~out_valid | out_ready; in_ready = adv; when low every stage holds.
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready           input handshake; in_data (WIDTH) word, in_tag (TAG_W) sideband
//   out_valid/out_ready         output handshake
//   out_count (CW)              leading zeros 0..WIDTH, plain binary
//   out_zero                    input was all zeros (== out_count MSB)
//   out_tag (TAG_W)             tag of the word this result belongs to
//   out_norm (WIDTH)            only with LZC_PIPE_NORM_EN: in_data << out_count, zero fill
//
// Optional feature macro: LZC_PIPE_NORM_EN (adds out_norm and the data-carry registers).

module lzc_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH):0]       out_count,
  output logic                         out_zero,
  output logic [TAG_W-1:0]             out_tag
`ifdef LZC_PIPE_NORM_EN
  ,
  output logic [WIDTH-1:0]             out_norm
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int CW     = LEVELS + 1;

  logic              adv;
  logic [LEVELS-1:0] vld_q;
  logic [TAG_W-1:0]  tag_q [LEVELS];

  // The last stage is the output register, so a free or draining output lets
  // the whole pipe move; there is no per-stage bubble collapsing.
  assign adv      = ~vld_q[LEVELS-1] | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < LEVELS; i++) tag_q[i] <= '0;
    end else if (adv) begin
      vld_q    <= {vld_q[LEVELS-2:0], in_valid};
      tag_q[0] <= in_tag;
      for (int i = 1; i < LEVELS; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Level k holds WIDTH>>(k+1) fields of k+2 bits each. A field is the
  // leading-zero count of its chunk; the MSB alone set means "chunk all zero".
  // Field j covers the j-th chunk from the LSB, so field 2j+1 is the high half.
  for (genvar k = 0; k < LEVELS; k++) begin : lvl
    localparam int NF = WIDTH >> (k + 1);
    localparam int FW = k + 2;

    logic [NF*FW-1:0] fld_d;
    logic [NF*FW-1:0] fld_q;

    if (k == 0) begin : g_enc
      for (genvar j = 0; j < NF; j++) begin : g_e
        enc u_enc (
          .d (in_data[2*j +: 2]),
          .q (fld_d[2*j +: 2])
        );
      end
    end else begin : g_mrg
      for (genvar j = 0; j < NF; j++) begin : g_m
        lzc #(.N(k + 1)) u_lzc (
          .hi (lvl[k-1].fld_q[(2*j+1)*(k+1) +: (k+1)]),
          .lo (lvl[k-1].fld_q[(2*j)*(k+1)   +: (k+1)]),
          .q  (fld_d[j*FW +: FW])
        );
      end
    end

    // Payload moves with adv regardless of the slot's valid bit.
    always_ff @(posedge clk) begin
      if (reset)    fld_q <= '0;
      else if (adv) fld_q <= fld_d;
    end
  end

  assign out_valid = vld_q[LEVELS-1];
  assign out_count = lvl[LEVELS-1].fld_q;
  assign out_zero  = out_count[CW-1];
  assign out_tag   = tag_q[LEVELS-1];

`ifdef LZC_PIPE_NORM_EN
  logic [WIDTH-1:0] dat_q [LEVELS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LEVELS; i++) dat_q[i] <= '0;
    end else if (adv) begin
      dat_q[0] <= in_data;
      for (int i = 1; i < LEVELS; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  // Shifting by WIDTH (all-zero word) yields 0, and both operands are
  // registers, so the result holds whenever the pipe holds.
  assign out_norm = dat_q[LEVELS-1] << out_count;
`endif

endmodule

// enc: 2-bit pair encoder -> 2-bit leading-zero field (00:2 -> 10, 01:1 -> 01, 1x:0 -> 00).
// Latency: combinational.
// Backpressure: none.
module enc (
  input  logic [1:0] d,
  output logic [1:0] q
);
  assign q = {~d[1] & ~d[0], ~d[1] & d[0]};
endmodule

// lzc: merges two N-bit leading-zero fields (high and low halves) into one N+1-bit field.
// Latency: combinational.
// Backpressure: none.
module lzc #(
  parameter int N = 2
) (
  input  logic [N-1:0] hi,
  input  logic [N-1:0] lo,
  output logic [N:0]   q
);
  // High half all zero: count = 2^(N-1) + low count, i.e. bits {0,1,lo_rest}.
  // Both all zero: only the new MSB set.
  assign q = {hi[N-1] & lo[N-1],
              hi[N-1] & ~lo[N-1],
              hi[N-1] ? lo[N-2:0] : hi[N-2:0]};
endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: self-checking bench for lzc_pipe (WIDTH=32, TAG_W=4).
// Latency: n/a.
// Backpressure: exercised by directed stalls and random out_ready.

module tb_lzc_pipe;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 4;
  localparam int LEVELS = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        out_count;
  logic              out_zero;
  logic [TAG_W-1:0]  out_tag;
`ifdef LZC_PIPE_NORM_EN
  logic [WIDTH-1:0]  out_norm;
`endif

  lzc_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
`ifdef LZC_PIPE_NORM_EN
    ,
    .out_norm  (out_norm)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: scan from the MSB for the first one.
  function automatic int ref_cnt(input logic [31:0] d);
    for (int b = WIDTH - 1; b >= 0; b--)
      if (d[b]) return WIDTH - 1 - b;
    return WIDTH;
  endfunction

  function automatic logic [31:0] ref_norm(input logic [31:0] d);
    int c;
    c = ref_cnt(d);
    return (c == WIDTH) ? 32'h0 : (d << c);
  endfunction

  // Scoreboard of accepted words in acceptance order.
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    int          stamp;
  } rec_t;
  rec_t sb[$];
  int   adv_cnt = 0;

  // Monitor at the falling edge: values here are what the next rising edge samples.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("mon_count", out_count, ref_cnt(sb[0].d));
          chk("mon_zero",  out_zero,  sb[0].d == 32'h0);
          chk("mon_tag",   out_tag,   sb[0].t);
`ifdef LZC_PIPE_NORM_EN
          chk("mon_norm",  out_norm,  ref_norm(sb[0].d));
`endif
          if (out_ready) begin
            chk("mon_latency", adv_cnt - sb[0].stamp, LEVELS);
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) sb.push_back('{d: in_data, t: in_tag, stamp: adv_cnt});
      if (in_ready) adv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic send_one(input logic [31:0] d, input logic [3:0] t,
                          input logic [5:0] c, input logic z, input logic [31:0] nrm);
    int lat;
    in_valid  = 1'b1;
    in_data   = d;
    in_tag    = t;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("single_latency", lat, LEVELS);
    chk("single_count", out_count, c);
    chk("single_zero", out_zero, z);
    chk("single_tag", out_tag, t);
`ifdef LZC_PIPE_NORM_EN
    chk("single_norm", out_norm, nrm);
`else
    if (nrm === 32'hx) $display("bad norm table entry");
`endif
    tick();
  endtask

  // Drive pat[0..n-1] as in_valid, tag = slot index; out_valid must replay the
  // same pattern LEVELS edges later with matching tags.
  task automatic stream(input logic [15:0] pat, input int n);
    int s;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < n + LEVELS + 1; cyc++) begin
      in_valid = (cyc < n) ? pat[cyc] : 1'b0;
      in_data  = $urandom >> $urandom_range(0, 32);
      in_tag   = cyc[3:0];
      tick();
      s = cyc - (LEVELS - 1);
      if (s >= 0 && s < n) begin
        chk("stream_valid", out_valid, pat[s]);
        if (pat[s]) chk("stream_tag", out_tag, s[3:0]);
      end else begin
        chk("stream_valid_idle", out_valid, 1'b0);
      end
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic [5:0]  c;
    logic        z;
    logic [31:0] n;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] bp_d0;
  int          took;
  int          seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h8000_0000, 4'h1, 6'd0,  1'b0, 32'h8000_0000};
    vecs[1] = '{32'h0001_0000, 4'h2, 6'd15, 1'b0, 32'h8000_0000};
    vecs[2] = '{32'h0000_0001, 4'h3, 6'd31, 1'b0, 32'h8000_0000};
    vecs[3] = '{32'h0000_0000, 4'h4, 6'd32, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0F00_00FF, 4'h5, 6'd4,  1'b0, 32'hF000_0FF0};
    vecs[5] = '{32'h0000_3A00, 4'h6, 6'd18, 1'b0, 32'hE800_0000};
    vecs[6] = '{32'h7FFF_FFFF, 4'h7, 6'd1,  1'b0, 32'hFFFF_FFFE};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 6'd0);
    chk("rst_out_zero",  out_zero,  1'b0);
    chk("rst_out_tag",   out_tag,   4'd0);
    chk("rst_in_ready",  in_ready,  1'b1);
`ifdef LZC_PIPE_NORM_EN
    chk("rst_out_norm",  out_norm,  32'h0);
`endif
    reset = 1'b0;
    tick();

    // Table of single words.
    for (int i = 0; i < 7; i++)
      send_one(vecs[i].d, vecs[i].t, vecs[i].c, vecs[i].z, vecs[i].n);

    // Single-bit sweep.
    for (int i = 0; i < 32; i++)
      send_one(32'h1 << i, i[3:0], 6'(31 - i), 1'b0, 32'h8000_0000);
    drain();

    // Back-to-back 8 words, then the bubble pattern 1,0,1,0,0,1.
    stream(16'h00FF, 8);
    drain();
    stream(16'b10_0101, 6);
    drain();

    // Backpressure: fill the pipe, stall the output 4 cycles with a word waiting.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < LEVELS; i++) begin
      in_data = $urandom >> $urandom_range(0, 31);
      in_tag  = i[3:0];
      if (i == 0) bp_d0 = in_data;
      tick();
    end
    chk("bp_full_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    in_data   = 32'h00C0_FFEE;
    in_tag    = 4'hA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready_low", in_ready, 1'b0);
      tick();
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_count", out_count, ref_cnt(bp_d0));
      chk("bp_hold_zero",  out_zero,  bp_d0 == 32'h0);
      chk("bp_hold_tag",   out_tag,   4'h0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();

    // Reset with three words in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h0000_0100 << i;
      in_tag  = 4'(i + 8);
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_count", out_count, 6'd0);
    chk("mid_rst_in_ready",  in_ready,  1'b1);
    seen = 0;
    for (int i = 0; i < 3 * LEVELS; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_rst_no_ghosts", seen, 0);

    // Random traffic with random output backpressure; the monitor checks it all.
    took = 1;
    for (int i = 0; i < 1500; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took != 0) begin
        in_valid = $urandom_range(0, 1);
        in_data  = $urandom >> $urandom_range(0, 32);
        in_tag   = 4'($urandom);
      end
      #1;
      took = (in_valid && in_ready) ? 1 : 0;
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
